// File: rtl/uart_rx_fsmd.sv
// uart_rx_fsmd: oversampling UART receiver (start, LSB-first data, optional parity, stop); data_valid one clk after stop sample.
// No backpressure: each word is presented once with a one-cycle pulse. Define UART_RX_MAJORITY_EN for 3-sample majority voting.
module uart_rx_fsmd #(
    parameter int data_size           = 8,
    parameter int sampling_cntr_width = 4,
    parameter int parity_on           = 1,
    parameter int even_parity         = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           Rx_s,
    input  logic [sampling_cntr_width-1:0] sampling_end_val,
    output logic [data_size-1:0]           Rx_data,
    output logic                           data_valid,
    output logic                           parity_err,
    output logic                           frame_err,
    output logic                           busy
);
    localparam int W  = sampling_cntr_width;
    localparam int IW = $clog2(data_size);
    localparam logic [W-1:0]  CNT_ONE  = W'(1);
    localparam logic [IW-1:0] IDX_ONE  = IW'(1);
    localparam logic [IW-1:0] IDX_LAST = IW'(data_size - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                state, nxt;
    logic                  rx_meta, rx_q, rx_prev;
    logic [W-1:0]          cnt, mid;
    logic [IW-1:0]         bit_idx;
    logic [data_size-1:0]  shift_reg;
    logic                  parity_bit, exp_parity, par_mismatch;
    logic                  fall, at_end, samp_now, bit_sample;

    assign mid    = sampling_end_val >> 1;
    assign at_end = (cnt == sampling_end_val);
    assign fall   = rx_prev & ~rx_q;

`ifdef UART_RX_MAJORITY_EN
    logic s_lo, s_mid;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s_lo  <= 1'b1;
            s_mid <= 1'b1;
        end else begin
            if (cnt == mid - CNT_ONE) s_lo  <= rx_q;
            if (cnt == mid)           s_mid <= rx_q;
        end
    end
    // Decision taken one count late so the third vote is the live rx_q.
    assign samp_now   = (cnt == mid + CNT_ONE);
    assign bit_sample = (s_lo & s_mid) | (s_lo & rx_q) | (s_mid & rx_q);
`else
    assign samp_now   = (cnt == mid);
    assign bit_sample = rx_q;
`endif

    assign exp_parity   = (even_parity != 0) ? ^shift_reg : ~^shift_reg;
    assign par_mismatch = (parity_on != 0) ? (parity_bit != exp_parity) : 1'b0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= nxt;
    end

    always_comb begin
        nxt  = state;
        busy = (state != IDLE);
        case (state)
            IDLE:    if (fall) nxt = START;
            START: begin
                if (samp_now && bit_sample) nxt = IDLE;
                else if (at_end)            nxt = DATA;
            end
            DATA:    if (at_end && bit_idx == IDX_LAST) nxt = (parity_on != 0) ? PARITY : STOP;
            PARITY:  if (at_end) nxt = STOP;
            STOP:    if (samp_now) nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta    <= 1'b1;
            rx_q       <= 1'b1;
            rx_prev    <= 1'b1;
            cnt        <= '0;
            bit_idx    <= '0;
            shift_reg  <= '0;
            parity_bit <= 1'b0;
            Rx_data    <= '0;
            data_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rx_meta    <= Rx_s;
            rx_q       <= rx_meta;
            rx_prev    <= rx_q;
            data_valid <= 1'b0;

            if (state == IDLE || at_end) cnt <= '0;
            else                         cnt <= cnt + CNT_ONE;

            if (state == START)                  bit_idx <= '0;
            else if (state == DATA && at_end)    bit_idx <= bit_idx + IDX_ONE;

            if (state == DATA && samp_now)   shift_reg[bit_idx] <= bit_sample;
            if (state == PARITY && samp_now) parity_bit <= bit_sample;

            // Word is delivered even on error; flags hold until the next word.
            if (state == STOP && samp_now) begin
                Rx_data    <= shift_reg;
                parity_err <= par_mismatch;
                frame_err  <= ~bit_sample;
                data_valid <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_uart_rx_fsmd.sv
// Scoreboard bench for uart_rx_fsmd at 16 clks/bit, 8 data bits, even parity.
module tb_uart_rx_fsmd;
    logic       clk = 1'b0;
    logic       rst;
    logic       Rx_s;
    logic [3:0] sampling_end_val;
    logic [7:0] Rx_data;
    logic       data_valid, parity_err, frame_err, busy;

    typedef struct packed {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
    } exp_t;

    exp_t sb[$];
    int   dv_cyc[$];
    int   checks = 0;
    int   errors = 0;
    int   dv_count = 0;
    int   cyc = 0;

    always #5 clk = ~clk;

    uart_rx_fsmd dut (
        .clk(clk), .rst(rst), .Rx_s(Rx_s), .sampling_end_val(sampling_end_val),
        .Rx_data(Rx_data), .data_valid(data_valid), .parity_err(parity_err),
        .frame_err(frame_err), .busy(busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    exp_t e_mon;
    always @(negedge clk) begin
        if (data_valid === 1'b1) begin
            dv_count++;
            dv_cyc.push_back(cyc);
            check("dv_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e_mon = sb.pop_front();
                check("rx_data",    32'(Rx_data),    32'(e_mon.data));
                check("parity_err", 32'(parity_err), 32'(e_mon.perr));
                check("frame_err",  32'(frame_err),  32'(e_mon.ferr));
            end
        end
    end

    // Drives one 11-bit frame; glitch_bit >= 0 inverts the line for one clk at mid of that data bit.
    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop, input int glitch_bit);
        logic [10:0] bits;
        logic [7:0]  rd;
        exp_t        e;
        rd = d;
`ifndef UART_RX_MAJORITY_EN
        if (glitch_bit >= 0) rd[glitch_bit] = ~rd[glitch_bit];
`endif
        e.data = rd;
        e.perr = (par != ^rd);
        e.ferr = ~stop;
        sb.push_back(e);
        bits = {stop, par, d, 1'b0};
        for (int b = 0; b < 11; b++) begin
            for (int s = 0; s < 16; s++) begin
                @(negedge clk);
                Rx_s = bits[b] ^ (glitch_bit >= 0 && b == glitch_bit + 1 && s == 8);
            end
        end
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 64 && sb.size() != 0; i++) @(negedge clk);
        check(tag, 32'(sb.size()), 32'd0);
    endtask

    task automatic idle_bits(input int n);
        Rx_s = 1'b1;
        repeat (n * 16) @(negedge clk);
    endtask

    initial begin
        int  n0, base;
        logic seen_busy;
        rst = 1'b0;
        Rx_s = 1'b1;
        sampling_end_val = 4'd15;
        repeat (3) @(negedge clk);
        check("rst_rx_data", 32'(Rx_data),    32'h0);
        check("rst_dv",      32'(data_valid), 32'h0);
        check("rst_perr",    32'(parity_err), 32'h0);
        check("rst_ferr",    32'(frame_err),  32'h0);
        check("rst_busy",    32'(busy),       32'h0);
        rst = 1'b1;
        idle_bits(2);

        send_frame(8'hA5, 1'b0, 1'b1, -1);
        wait_drain("nominal_drain");
        idle_bits(1);
        check("nominal_busy_after", 32'(busy), 32'h0);

        n0 = dv_count;
        seen_busy = 1'b0;
        Rx_s = 1'b0;
        repeat (4) @(negedge clk);
        Rx_s = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (busy) seen_busy = 1'b1;
        end
        check("false_start_busy_seen", 32'(seen_busy), 32'h1);
        check("false_start_idle",      32'(busy),      32'h0);
        check("false_start_no_dv",     32'(dv_count),  32'(n0));
        check("false_start_rx_hold",   32'(Rx_data),   32'hA5);

        send_frame(8'h3C, 1'b1, 1'b1, -1);
        wait_drain("parity_err_drain");
        idle_bits(1);
        send_frame(8'h01, 1'b1, 1'b0, -1);
        wait_drain("frame_err_drain");
        n0 = dv_count;
        Rx_s = 1'b0;
        repeat (320) @(negedge clk);
        check("break_no_dv", 32'(dv_count), 32'(n0));
        check("flags_hold_ferr", 32'(frame_err), 32'h1);
        idle_bits(2);

        base = dv_cyc.size();
        send_frame(8'h55, 1'b0, 1'b1, -1);
        send_frame(8'hAA, 1'b0, 1'b1, -1);
        wait_drain("b2b_drain");
        check("b2b_pulses", 32'(dv_cyc.size() - base), 32'd2);
        if (dv_cyc.size() >= base + 2)
            check("b2b_gap", 32'(dv_cyc[base + 1] - dv_cyc[base]), 32'd176);
        idle_bits(1);

        n0 = dv_count;
        Rx_s = 1'b0;
        repeat (16) @(negedge clk);
        for (int i = 0; i < 72; i++) begin
            @(negedge clk);
            Rx_s = 1'b1;
        end
        check("busy_before_rst", 32'(busy), 32'h1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("mid_rst_rx_data", 32'(Rx_data),    32'h0);
        check("mid_rst_busy",    32'(busy),       32'h0);
        check("mid_rst_dv",      32'(data_valid), 32'h0);
        check("mid_rst_perr",    32'(parity_err), 32'h0);
        check("mid_rst_ferr",    32'(frame_err),  32'h0);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        idle_bits(3);
        check("mid_rst_no_dv", 32'(dv_count), 32'(n0));
        send_frame(8'h81, 1'b0, 1'b1, -1);
        wait_drain("after_rst_drain");
        idle_bits(1);

        send_frame(8'hA5, 1'b0, 1'b1, 1);
        wait_drain("glitch_drain");
        idle_bits(1);

        check("dv_total", 32'(dv_count), 32'd7);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
